mod_counter_ctrl: RTL and testbench

Run-time controller for the modulo counter datapath: accepts a modulus and repeat count over a valid/ready configuration port, then sequences a programmable mod counter through start, pause, abort and terminal-count completion. Sits between a host/sequencer and counter-driven logic, replacing the fixed-modulus counter with a configurable, schedulable timer that reports each wrap and end of job.

---
 rtl/mod_ctrl_pkg.sv | 14 +
 rtl/mod_counter_core.sv | 49 ++++
 rtl/mod_counter_ctrl.sv | 105 ++++++++++
 tb/tb_mod_counter_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mod_ctrl_pkg.sv
// Shared types and constants for the run-time modulo counter controller.
// The state encoding is shared so the top and any debug logic agree on it.
package mod_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_MOD = 10;

endpackage

// File: rtl/mod_counter_core.sv
// Programmable modulus counter: counts 0..mod-1 while enabled and pulses wrap
// (registered) in the cycle the count has just returned to zero.
module mod_counter_core
  import mod_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] mod_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // mod 0 underflows to all-ones, giving a full 2^WIDTH period for free;
  // mod 1 makes every cycle terminal so the count holds 0 and wraps each edge.
  assign tc_o = (count_q == (mod_i - WIDTH'(1)));

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + WIDTH'(1);
      wrap_d  = tc_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run-time controller around mod_counter_core: config port, job FSM
// (IDLE/RUN/PAUSED/DONE), wrap counting and end-of-job pulse.
module mod_counter_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REPW  = 4,
  parameter int N     = DEFAULT_MOD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_mod_i,
  input  logic [REPW-1:0]  cfg_reps_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             done_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mod_q;
  logic [REPW-1:0]  reps_q;
  logic [REPW-1:0]  wrapCnt_q;
  logic             done_q;
  logic             cntEn, cntClr, termCount;
  logic             cfgAccept, abortHit, lastWrap, startHit;

  assign cfgAccept = cfg_valid_i && cfg_ready_o;
  assign startHit  = (state_q == IDLE) && start_i;
  assign abortHit  = abort_i && (state_q != IDLE);
  // The comparison is skipped for reps 0, so a free-running job never ends.
  assign lastWrap  = (reps_q != '0) && (wrapCnt_q == (reps_q - REPW'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN, PAUSED: begin
        if (abort_i)                    state_d = IDLE;
        else if (pause_i)               state_d = PAUSED;
        else if (termCount && lastWrap) state_d = DONE;
        else                            state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving PAUSED with pause low counts at that same edge, hence PAUSED here.
  always_comb begin
    busy_o      = (state_q != IDLE);
    cfg_ready_o = (state_q == IDLE);
    cntEn       = ((state_q == RUN) || (state_q == PAUSED)) && !abort_i && !pause_i;
    cntClr      = (state_q == IDLE) || (state_q == DONE) || abortHit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mod_q  <= WIDTH'(N);
      reps_q <= '0;
    end else if (cfgAccept) begin
      mod_q  <= cfg_mod_i;
      reps_q <= cfg_reps_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || startHit) begin
      wrapCnt_q <= '0;
    end else if (cntEn && termCount && (wrapCnt_q != '1)) begin
      wrapCnt_q <= wrapCnt_q + REPW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) done_q <= 1'b0;
    else       done_q <= (state_d == DONE);
  end

  assign done_o = done_q;

  mod_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (cntEn),
    .clr_i  (cntClr),
    .mod_i  (mod_q),
    .count_o(count_o),
    .wrap_o (wrap_o),
    .tc_o   (termCount)
  );

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: a vector table for the main job flows
// plus hand-written loops for free-run, M=1, M=0 and mid-job config/reset.
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfgValid, cfgReady, start, pause, abort;
  logic [3:0] cfgMod, cfgReps, count;
  logic       wrap, done, busy;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string      tag;
    bit         rst, cfgValid;
    logic [3:0] cfgMod, cfgReps;
    bit         start, pause, abort;
    logic [3:0] eCount;
    bit         eWrap, eDone, eBusy, eRdy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mod_counter_ctrl #(.WIDTH(4), .REPW(4), .N(10)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_valid_i(cfgValid),
    .cfg_ready_o(cfgReady),
    .cfg_mod_i  (cfgMod),
    .cfg_reps_i (cfgReps),
    .start_i    (start),
    .pause_i    (pause),
    .abort_i    (abort),
    .count_o    (count),
    .wrap_o     (wrap),
    .done_o     (done),
    .busy_o     (busy)
  );

  function automatic vec_t mk(input string tag, input bit r, input bit cv, input int m,
                              input int rp, input bit st, input bit pa, input bit ab,
                              input int ec, input bit ew, input bit ed, input bit eb,
                              input bit er);
    vec_t v;
    v.tag = tag; v.rst = r; v.cfgValid = cv;
    v.cfgMod = m[3:0]; v.cfgReps = rp[3:0];
    v.start = st; v.pause = pa; v.abort = ab;
    v.eCount = ec[3:0]; v.eWrap = ew; v.eDone = ed; v.eBusy = eb; v.eRdy = er;
    return v;
  endfunction

  task automatic checkField(input string tag, input string field, input int actual,
                            input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s.%s: got %0d expected %0d", tag, field, actual, expected);
  endtask

  task automatic checkOutput(input vec_t v);
    checkField(v.tag, "count",     int'(count),    int'(v.eCount));
    checkField(v.tag, "wrap",      int'(wrap),     int'(v.eWrap));
    checkField(v.tag, "done",      int'(done),     int'(v.eDone));
    checkField(v.tag, "busy",      int'(busy),     int'(v.eBusy));
    checkField(v.tag, "cfg_ready", int'(cfgReady), int'(v.eRdy));
  endtask

  // Inputs change just after the falling edge; outputs are checked at the next one.
  task automatic applyStimulus(input vec_t v);
    rst = v.rst; cfgValid = v.cfgValid; cfgMod = v.cfgMod; cfgReps = v.cfgReps;
    start = v.start; pause = v.pause; abort = v.abort;
    @(posedge clk);
    @(negedge clk);
    checkOutput(v);
  endtask

  initial begin
    rst = 1'b1; cfgValid = 1'b0; cfgMod = '0; cfgReps = '0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    @(negedge clk);

    vecs.push_back(mk("rst",   1,0,0,0,0,0,0, 0,0,0,0,1));
    // M=3 R=2
    vecs.push_back(mk("A_c1",  0,1,3,2,1,0,0, 0,0,0,1,0));
    vecs.push_back(mk("A_c2",  0,0,0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk("A_c3",  0,0,0,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk("A_c4",  0,0,0,0,0,0,0, 0,1,0,1,0));
    vecs.push_back(mk("A_c5",  0,0,0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk("A_c6",  0,0,0,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk("A_c7",  0,0,0,0,0,0,0, 0,1,1,1,0));
    vecs.push_back(mk("A_c8",  0,0,0,0,0,0,0, 0,0,0,0,1));
    // Same config, pause held for two edges at count 1
    vecs.push_back(mk("B_c1",  0,0,0,0,1,0,0, 0,0,0,1,0));
    vecs.push_back(mk("B_c2",  0,0,0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk("B_c3",  0,0,0,0,0,1,0, 1,0,0,1,0));
    vecs.push_back(mk("B_c4",  0,0,0,0,0,1,0, 1,0,0,1,0));
    vecs.push_back(mk("B_c5",  0,0,0,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk("B_c6",  0,0,0,0,0,0,0, 0,1,0,1,0));
    vecs.push_back(mk("B_c7",  0,0,0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk("B_c8",  0,0,0,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk("B_c9",  0,0,0,0,0,0,0, 0,1,1,1,0));
    vecs.push_back(mk("B_c10", 0,0,0,0,0,0,0, 0,0,0,0,1));
    // M=5 R=3, abort at count 3 of the second lap, then a new config runs
    vecs.push_back(mk("C_c1",  0,1,5,3,1,0,0, 0,0,0,1,0));
    vecs.push_back(mk("C_c2",  0,0,0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk("C_c3",  0,0,0,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk("C_c4",  0,0,0,0,0,0,0, 3,0,0,1,0));
    vecs.push_back(mk("C_c5",  0,0,0,0,0,0,0, 4,0,0,1,0));
    vecs.push_back(mk("C_c6",  0,0,0,0,0,0,0, 0,1,0,1,0));
    vecs.push_back(mk("C_c7",  0,0,0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk("C_c8",  0,0,0,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk("C_c9",  0,0,0,0,0,0,0, 3,0,0,1,0));
    vecs.push_back(mk("C_abt", 0,0,0,0,0,0,1, 0,0,0,0,1));
    vecs.push_back(mk("C_cfg", 0,1,7,1,0,0,0, 0,0,0,0,1));
    vecs.push_back(mk("C_j1",  0,0,0,0,1,0,0, 0,0,0,1,0));
    for (int c = 2; c <= 7; c++)
      vecs.push_back(mk($sformatf("C_j%0d", c), 0,0,0,0,0,0,0, c-1,0,0,1,0));
    vecs.push_back(mk("C_j8",  0,0,0,0,0,0,0, 0,1,1,1,0));
    vecs.push_back(mk("C_j9",  0,0,0,0,0,0,0, 0,0,0,0,1));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Default N=10, R=0 after reset: free-running, never done
    applyStimulus(mk("D_rst", 1,0,0,0,0,0,0, 0,0,0,0,1));
    applyStimulus(mk("D_c1",  0,0,0,0,1,0,0, 0,0,0,1,0));
    for (int c = 2; c <= 32; c++)
      applyStimulus(mk($sformatf("D_c%0d", c), 0,0,0,0,0,0,0,
                       (c-1) % 10, ((c-1) % 10) == 0, 0, 1, 0));
    applyStimulus(mk("D_abt", 0,0,0,0,0,0,1, 0,0,0,0,1));

    // M=1, R=2: wraps every cycle, done on the second
    applyStimulus(mk("E_c1",  0,1,1,2,1,0,0, 0,0,0,1,0));
    applyStimulus(mk("E_c2",  0,0,0,0,0,0,0, 0,1,0,1,0));
    applyStimulus(mk("E_c3",  0,0,0,0,0,0,0, 0,1,1,1,0));
    applyStimulus(mk("E_c4",  0,0,0,0,0,0,0, 0,0,0,0,1));

    // M=0 means 16, R=1: count reaches 15, done in cycle 17
    applyStimulus(mk("F_c1",  0,1,0,1,1,0,0, 0,0,0,1,0));
    for (int c = 2; c <= 16; c++)
      applyStimulus(mk($sformatf("F_c%0d", c), 0,0,0,0,0,0,0, c-1,0,0,1,0));
    applyStimulus(mk("F_c17", 0,0,0,0,0,0,0, 0,1,1,1,0));
    applyStimulus(mk("F_c18", 0,0,0,0,0,0,0, 0,0,0,0,1));

    // M=6 R=0, config offered mid-run must stall, then reset at count 4
    applyStimulus(mk("G_c1",  0,1,6,0,1,0,0, 0,0,0,1,0));
    for (int c = 2; c <= 5; c++)
      applyStimulus(mk($sformatf("G_c%0d", c), 0,1,2,1,0,0,0, c-1,0,0,1,0));
    applyStimulus(mk("G_rst", 1,0,0,0,0,0,0, 0,0,0,0,1));
    // Config must be back to N=10, R=0: wrap at cycle 11 and no done
    applyStimulus(mk("G_r1",  0,0,0,0,1,0,0, 0,0,0,1,0));
    for (int c = 2; c <= 12; c++)
      applyStimulus(mk($sformatf("G_r%0d", c), 0,0,0,0,0,0,0,
                       (c-1) % 10, ((c-1) % 10) == 0, 0, 1, 0));
    applyStimulus(mk("G_abt", 0,0,0,0,0,0,1, 0,0,0,0,1));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
